// File: rtl/sram_scan_driver.sv
// sram_scan_driver
// Scan master for the SRAM scan wrapper. Takes one parallel command at a time,
// pulses the target reset, then shifts the header {addr, cnt, write} and the
// write data LSB first. For reads it waits RD_WAIT cycles and deserializes the
// returned word.
//
// Ports:
//   clk_1       in   scan clock, all logic on posedge
//   rst_n_sync  in   asynchronous active-low reset
//   cmd_valid   in   command present
//   cmd_ready   out  driver idle and able to accept a command
//   cmd_addr    in   [N_addr-1:0]  start address
//   cmd_cnt     in   [N_cnt-2:0]   burst count
//   cmd_write   in   1 = write, 0 = read
//   cmd_wdata   in   [N_data-1:0]  write data (shifted on reads too)
//   scan_rst_n  out  target rst_n
//   scan_data   out  target scan_in
//   scan_ret    in   target scan_out
//   rd_valid    out  one-cycle pulse, rd_data valid
//   rd_data     out  [N_data-1:0]  captured read word
//   wr_done     out  one-cycle pulse at end of a write session
//   busy        out  (SCAN_DRV_STATUS_EN only) FSM not IDLE
//   xact_cnt    out  [15:0] (SCAN_DRV_STATUS_EN only) completed sessions, wraps
//
// Optional feature macro: SCAN_DRV_STATUS_EN adds busy and xact_cnt.
module sram_scan_driver #(
    parameter int N_addr     = 31,
    parameter int N_cnt      = 32,
    parameter int N_data     = 32,
    parameter int RST_CYCLES = 2,
    parameter int RD_WAIT    = 64
) (
    input  logic              clk_1,
    input  logic              rst_n_sync,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [N_addr-1:0] cmd_addr,
    input  logic [N_cnt-2:0]  cmd_cnt,
    input  logic              cmd_write,
    input  logic [N_data-1:0] cmd_wdata,
    output logic              scan_rst_n,
    output logic              scan_data,
    input  logic              scan_ret,
    output logic              rd_valid,
    output logic [N_data-1:0] rd_data,
    output logic              wr_done
`ifdef SCAN_DRV_STATUS_EN
    ,
    output logic              busy,
    output logic [15:0]       xact_cnt
`endif
);

    localparam int HDR_W = N_addr + N_cnt;
    localparam int MAX_A = (HDR_W > N_data) ? HDR_W : N_data;
    localparam int MAX_B = (RD_WAIT > RST_CYCLES) ? RD_WAIT : RST_CYCLES;
    localparam int MAXL  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = (MAXL > 1) ? $clog2(MAXL) : 1;

    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] HDR_LAST  = CW'(HDR_W - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(N_data - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'((RD_WAIT > 0) ? RD_WAIT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_HDR, S_DATA, S_WAIT, S_CAPT, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic              live_q;   // low until the first edge after reset release
    logic [HDR_W-1:0]  hdr_q;
    logic [N_data-1:0] wd_q;
    logic              wr_q;
    logic [N_data-1:0] sh_q;
    logic [N_data-1:0] rd_q;
    logic              accept;

    always_comb begin
        state_d    = state_q;
        accept     = cmd_valid && live_q && (state_q == S_IDLE);
        cmd_ready  = live_q && (state_q == S_IDLE);
        scan_rst_n = live_q && (state_q != S_RST);
        scan_data  = 1'b0;
        rd_valid   = 1'b0;
        wr_done    = 1'b0;
        rd_data    = rd_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_RST;
            S_RST:  if (cnt_q == RST_LAST) state_d = S_HDR;
            S_HDR: begin
                scan_data = hdr_q[0];
                if (cnt_q == HDR_LAST) state_d = S_DATA;
            end
            S_DATA: begin
                scan_data = wd_q[0];
                if (cnt_q == DATA_LAST) begin
                    if (wr_q)              state_d = S_DONE;
                    else if (RD_WAIT == 0) state_d = S_CAPT;
                    else                   state_d = S_WAIT;
                end
            end
            S_WAIT: if (cnt_q == WAIT_LAST) state_d = S_CAPT;
            S_CAPT: if (cnt_q == DATA_LAST) state_d = S_DONE;
            S_DONE: begin
                rd_valid = ~wr_q;
                wr_done  = wr_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_1 or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            live_q  <= 1'b0;
            hdr_q   <= '0;
            wd_q    <= '0;
            wr_q    <= 1'b0;
            sh_q    <= '0;
            rd_q    <= '0;
        end else begin
            live_q  <= 1'b1;
            state_q <= state_d;
            // Phase counter restarts on every state entry and is parked in IDLE.
            if ((state_d != state_q) || (state_q == S_IDLE))
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + 1'b1;

            if (accept) begin
                hdr_q <= {cmd_addr, cmd_cnt, cmd_write};
                wd_q  <= cmd_wdata;
                wr_q  <= cmd_write;
            end else if (state_q == S_HDR) begin
                hdr_q <= hdr_q >> 1;
            end else if (state_q == S_DATA) begin
                wd_q <= wd_q >> 1;
            end

            // Capture into a separate shifter so rd_data keeps the previous
            // word until the whole new word has been collected.
            if (state_q == S_CAPT) begin
                sh_q <= {scan_ret, sh_q[N_data-1:1]};
                if (cnt_q == DATA_LAST)
                    rd_q <= {scan_ret, sh_q[N_data-1:1]};
            end
        end
    end

`ifdef SCAN_DRV_STATUS_EN
    logic [15:0] xact_cnt_q;

    always_ff @(posedge clk_1 or negedge rst_n_sync) begin
        if (!rst_n_sync)
            xact_cnt_q <= '0;
        else if (state_q == S_DONE)
            xact_cnt_q <= xact_cnt_q + 16'd1;
    end

    assign busy     = (state_q != S_IDLE);
    assign xact_cnt = xact_cnt_q;
`endif

endmodule

// File: doc/sram_scan_driver.md
Name: sram_scan_driver

Overview:
- Scan master that produces the serial bitstream consumed by the SRAM scan wrapper and collects its serial read-back.
- Accepts one parallel command at a time (address, count, read/write, write data), serializes header and data LSB-first, and pulses the target reset around each session.
- For reads, deserializes the returned word.
- Sits between the test/debug controller (parallel side) and the scan-wrapped SRAM macro (serial side).

Parameters:
- N_addr, 31: address field width.
- N_cnt, 32: count field width. Bit 0 is the write flag; bits N_cnt-1:1 are the burst count.
- N_data, 32: data word width.
- RST_CYCLES, 2: cycles scan_rst_n is held low at session start (min 1).
- RD_WAIT, 64: cycles between the last data bit shifted and the first read-back bit sampled (min 0).

Ports:
- clk_1  input  1  scan clock; all logic on its posedge.
- rst_n_sync  input  1  reset, asynchronous, active-low.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  driver can accept a command.
- cmd_addr  input  N_addr  start address.
- cmd_cnt  input  N_cnt-1  burst count.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_wdata  input  N_data  write data (also shifted on reads, value ignored by target).
- scan_rst_n  output  1  drives target rst_n.
- scan_data  output  1  drives target scan_in.
- scan_ret  input  1  from target scan_out.
- rd_valid  output  1  one-cycle pulse, rd_data valid.
- rd_data  output  N_data  captured read word.
- wr_done  output  1  one-cycle pulse at end of a write session.

Behaviour:
- Clock and reset: reset rst_n_sync, asynchronous, active-low; clock clk_1.
- Reset values: cmd_ready=0 during reset, then 1 on the first cycle after release; scan_rst_n=0; scan_data=0; rd_valid=0; wr_done=0; rd_data=0; FSM=IDLE.
- Handshake: command is accepted on a posedge with cmd_valid&cmd_ready. cmd_ready=1 only in IDLE. All cmd_* fields are latched into a shadow register at acceptance and may change afterwards.
- Header word: hdr = {cmd_addr, cmd_cnt, cmd_write}, width N_addr+N_cnt. Shifted LSB first, so the write flag is the first bit.
- FSM states:
  - IDLE: scan_rst_n=1, scan_data=0. On accept -> RST.
  - RST: scan_rst_n=0 for RST_CYCLES cycles, scan_data=0 -> HDR.
  - HDR: scan_rst_n=1. scan_data=hdr[i] for i=0..N_addr+N_cnt-1, one bit per cycle -> DATA.
  - DATA: scan_data=wdata[j] for j=0..N_data-1 -> write: DONE; read: WAIT (or straight to CAPT if RD_WAIT=0).
  - WAIT: RD_WAIT cycles, scan_data=0 -> CAPT.
  - CAPT: N_data cycles. On capture cycle k, scan_ret is sampled into rd_data shift register bit k, so the first sampled bit becomes rd_data[0]. scan_data=0 -> DONE.
  - DONE: one cycle. rd_valid=1 (read) or wr_done=1 (write); rd_data holds the final word -> IDLE.
- Latency (accept to done pulse):
  - Write: RST_CYCLES+N_addr+N_cnt+N_data+1 cycles (98 at defaults).
  - Read: that plus RD_WAIT+N_data (194 at defaults).
- Single bit counter sized $clog2 of the largest phase length (N_addr+N_cnt, N_data, RD_WAIT, RST_CYCLES). It reloads on every state entry and never wraps within a phase.
- rd_data holds its value until the next read capture completes. It is not cleared by writes.
- cmd_valid outside IDLE is ignored; no queuing.
- Reset mid-session: immediate return to IDLE with scan_rst_n=0. The partial session is abandoned, and no rd_valid or wr_done pulse is issued.
- scan_rst_n returns low only in RST. Back-to-back commands therefore always re-reset the target, because IDLE→RST happens on the accept cycle.

Optional Feature:
- Macro: SCAN_DRV_STATUS_EN.
- Defined: adds output busy (1 = FSM not IDLE, equal to ~cmd_ready when out of reset) and output xact_cnt[15:0]. xact_cnt increments on every DONE cycle, wraps 0xFFFF→0, and resets to 0.
- Undefined: neither port exists; the rest of the behaviour is identical.

Test Plan:
- Reset mid-HDR (assert rst_n_sync at header bit 20) → scan_rst_n=0, cmd_ready=0 during reset and 1 one cycle after release; no rd_valid or wr_done pulse.
- Write addr=0x00000005, cnt=3, wdata=0xA5A5A5A5 → scan_rst_n low 2 cycles; then scan_data bit0=1 (write flag), next 31 bits 3 LSB first, next 31 bits 5 LSB first, then 0xA5A5A5A5 LSB first; wr_done at cycle 98 after accept.
- Read addr=0x10, cnt=0 with a scan_ret model returning 0xDEADBEEF LSB first starting 64 cycles after the last data bit → rd_valid at cycle 194; rd_data=0xDEADBEEF.
- cmd_valid held high continuously, two commands back-to-back → second accepted only in the cycle after DONE; scan_rst_n pulses low again for 2 cycles; the second command's fields change mid-session without corrupting the first session.
- Parameter override RD_WAIT=0, N_data=8 with read → CAPT directly follows DATA; rd_data[7:0] equals the 8 sampled bits in order.
- With SCAN_DRV_STATUS_EN, 3 transactions → xact_cnt=3 and busy low in IDLE. Force xact_cnt=0xFFFF, run 1 transaction → xact_cnt=0.
